// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply engine.
// Build option: MATMUL_SATURATE_EN selects clamping of each C element instead of wrap.
// No timing or backpressure; constants and pure functions only.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Widest accumulator and element the narrowing helper has to handle.
    localparam int ACC_MAX_W = 128;
    localparam int RES_MAX_W = 64;

    // Full-precision product plus clog2(N) guard bits for the N-term sum.
    function automatic int acc_width(input int data_w, input int n);
        return 2 * data_w + $clog2(n);
    endfunction

    // Narrows a sign-extended accumulator to a w-bit element; callers keep the low w bits.
    function automatic logic [RES_MAX_W-1:0] result(input logic signed [ACC_MAX_W-1:0] acc,
                                                    input int w);
`ifdef MATMUL_SATURATE_EN
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
        hi = (ACC_MAX_W'(1) <<< (w - 1)) - ACC_MAX_W'(1);
        lo = -hi - ACC_MAX_W'(1);
        if (acc > hi) begin
            return RES_MAX_W'(hi);
        end
        if (acc < lo) begin
            return RES_MAX_W'(lo);
        end
        return RES_MAX_W'(acc);
`else
        logic [RES_MAX_W-1:0] mask;
        mask = (RES_MAX_W'(1) << w) - RES_MAX_W'(1);
        return RES_MAX_W'(acc) & mask;
`endif
    endfunction

endpackage

// File: rtl/matmul_if.sv
// Engine-side bundle: start/done handshake plus the A/B read ports and C write port.
// Reads are combinational (data same cycle as address); C write is a single-cycle strobe.
// No backpressure: memories always accept and always answer.
interface matmul_if #(
    parameter int BRAM_ADDR_WIDTH = 6,
    parameter int BRAM_DATA_WIDTH = 32
);
    logic                       start;
    logic                       busy;
    logic                       done;
    logic [BRAM_ADDR_WIDTH-1:0] a_rd_addr;
    logic [BRAM_DATA_WIDTH-1:0] a_dout;
    logic [BRAM_ADDR_WIDTH-1:0] b_rd_addr;
    logic [BRAM_DATA_WIDTH-1:0] b_dout;
    logic [BRAM_ADDR_WIDTH-1:0] c_wr_addr;
    logic                       c_wr_en;
    logic [BRAM_DATA_WIDTH-1:0] c_din;

    modport master (
        input  start, a_dout, b_dout,
        output busy, done, a_rd_addr, b_rd_addr, c_wr_addr, c_wr_en, c_din
    );

    modport slave (
        output start, a_dout, b_dout,
        input  busy, done, a_rd_addr, b_rd_addr, c_wr_addr, c_wr_en, c_din
    );
endinterface

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate with clear/enable and narrowing of the sum to one element.
// One MAC per cycle when en=1; dout reflects the registered accumulator (no added latency).
// No backpressure; clr has priority over en. Narrowing follows MATMUL_SATURATE_EN.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int MATRIX_SIZE     = 8,
    parameter int BRAM_DATA_WIDTH = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clr,
    input  logic                              en,
    input  logic signed [BRAM_DATA_WIDTH-1:0] a,
    input  logic signed [BRAM_DATA_WIDTH-1:0] b,
    output logic        [BRAM_DATA_WIDTH-1:0] dout
);
    localparam int DW    = BRAM_DATA_WIDTH;
    localparam int ACC_W = acc_width(DW, MATRIX_SIZE);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc;

    assign prod = a * b;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        end
    end

    assign dout = DW'(result({{(ACC_MAX_W-ACC_W){acc[ACC_W-1]}}, acc}, DW));

endmodule

// File: rtl/matmul_ctrl.sv
// C = A x B sequencer: FSM, i/j/k counters, row-major address generation, C write strobe.
// N cycles of MAC then one WRITE cycle per element; done pulses one cycle after the last write.
// No backpressure: memories are combinational; start is ignored unless IDLE.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int MATRIX_SIZE     = 8,
    parameter int BRAM_ADDR_WIDTH = 6,
    parameter int BRAM_DATA_WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    matmul_if.master bus
);
    localparam int              AW   = BRAM_ADDR_WIDTH;
    localparam int              CW   = $clog2(MATRIX_SIZE);
    localparam logic [CW-1:0]   LAST = CW'(MATRIX_SIZE - 1);
    localparam logic [AW-1:0]   N_A  = AW'(MATRIX_SIZE);

    state_t        state;
    logic [CW-1:0] i;
    logic [CW-1:0] j;
    logic [CW-1:0] k;
    logic          busy_q;
    logic          done_q;
    logic          wr_en_q;
    logic          mac_clr;
    logic          mac_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_MAC;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_MAC: begin
                    if (k == LAST) begin
                        k       <= '0;
                        state   <= ST_WRITE;
                        wr_en_q <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_WRITE: begin
                    k <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        i <= (i == LAST) ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                    if (i == LAST && j == LAST) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Accumulator starts fresh on accept and after each element is written out.
    assign mac_clr = (state == ST_IDLE && bus.start) || (state == ST_WRITE);
    assign mac_en  = (state == ST_MAC);

    matmul_mac #(
        .MATRIX_SIZE    (MATRIX_SIZE),
        .BRAM_DATA_WIDTH(BRAM_DATA_WIDTH)
    ) u_mac (
        .clock(clock),
        .reset(reset),
        .clr  (mac_clr),
        .en   (mac_en),
        .a    ($signed(bus.a_dout)),
        .b    ($signed(bus.b_dout)),
        .dout (bus.c_din)
    );

    assign bus.a_rd_addr = AW'(i) * N_A + AW'(k);
    assign bus.b_rd_addr = AW'(k) * N_A + AW'(j);
    assign bus.c_wr_addr = AW'(i) * N_A + AW'(j);
    assign bus.c_wr_en   = wr_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl: N=2 and N=8 instances with behavioural A/B/C memories.
// Expected results follow MATMUL_SATURATE_EN when it is defined for the build.
module tb_matmul_ctrl;
    logic clock = 1'b0;
    logic rst2  = 1'b1;
    logic rst8  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    matmul_if #(.BRAM_ADDR_WIDTH(2), .BRAM_DATA_WIDTH(32)) if2 ();
    matmul_if #(.BRAM_ADDR_WIDTH(6), .BRAM_DATA_WIDTH(32)) if8 ();

    matmul_ctrl #(.MATRIX_SIZE(2), .BRAM_ADDR_WIDTH(2), .BRAM_DATA_WIDTH(32)) dut2 (
        .clock(clock), .reset(rst2), .bus(if2.master));
    matmul_ctrl #(.MATRIX_SIZE(8), .BRAM_ADDR_WIDTH(6), .BRAM_DATA_WIDTH(32)) dut8 (
        .clock(clock), .reset(rst8), .bus(if8.master));

    logic [31:0] a2 [0:3];
    logic [31:0] b2 [0:3];
    logic [31:0] c2 [0:3];
    logic [31:0] a8 [0:63];
    logic [31:0] b8 [0:63];
    logic [31:0] c8 [0:63];
    logic [31:0] exp8 [0:63];
    logic        w8 [0:63];

    assign if2.a_dout = a2[if2.a_rd_addr];
    assign if2.b_dout = b2[if2.b_rd_addr];
    assign if8.a_dout = a8[if8.a_rd_addr];
    assign if8.b_dout = b8[if8.b_rd_addr];

    // Cycle n is the period ending at edge n; edge 0 is the one that samples start.
    int   cyc2 = 0, nwr2 = 0, ndone2 = 0, done_cyc2 = -1, consec2 = 0;
    int   wr_cyc2 [0:15];
    logic prev_wr2 = 1'b0;
    int   cyc8 = 0, nwr8 = 0, ndone8 = 0, done_cyc8 = -1, consec8 = 0, last_wr8 = -1;
    logic prev_wr8 = 1'b0;

    always @(negedge clock) begin
        cyc2 = cyc2 + 1;
        if (if2.c_wr_en) begin
            c2[if2.c_wr_addr] = if2.c_din;
            if (nwr2 < 16) wr_cyc2[nwr2] = cyc2;
            nwr2 = nwr2 + 1;
        end
        if (if2.c_wr_en && prev_wr2) consec2 = consec2 + 1;
        prev_wr2 = if2.c_wr_en;
        if (if2.done) begin
            ndone2    = ndone2 + 1;
            done_cyc2 = cyc2;
        end
    end

    always @(negedge clock) begin
        cyc8 = cyc8 + 1;
        if (if8.c_wr_en) begin
            c8[if8.c_wr_addr] = if8.c_din;
            w8[if8.c_wr_addr] = 1'b1;
            last_wr8 = cyc8;
            nwr8 = nwr8 + 1;
        end
        if (if8.c_wr_en && prev_wr8) consec8 = consec8 + 1;
        prev_wr8 = if8.c_wr_en;
        if (if8.done) begin
            ndone8    = ndone8 + 1;
            done_cyc8 = cyc8;
        end
    end

    task automatic go2();
        @(posedge clock); #1 if2.start = 1'b1;
        @(posedge clock); #1 if2.start = 1'b0;
        cyc2 = 0; nwr2 = 0; ndone2 = 0; done_cyc2 = -1; consec2 = 0;
    endtask

    task automatic go8();
        @(posedge clock); #1 if8.start = 1'b1;
        @(posedge clock); #1 if8.start = 1'b0;
        cyc8 = 0; nwr8 = 0; ndone8 = 0; done_cyc8 = -1; consec8 = 0; last_wr8 = -1;
    endtask

    // Returns in the done cycle (after the negedge sample), or when the budget runs out.
    task automatic wait2(input int budget);
        int n = 0;
        while (ndone2 == 0 && n < budget) begin
            @(negedge clock); #1;
            n++;
        end
    endtask

    task automatic wait8(input int budget);
        int n = 0;
        while (ndone8 == 0 && n < budget) begin
            @(negedge clock); #1;
            n++;
        end
    endtask

    function automatic logic [31:0] narrow(input longint s);
        longint hi;
        longint lo;
        hi = 64'sd2147483647;
        lo = -hi - 1;
`ifdef MATMUL_SATURATE_EN
        if (s > hi) return 32'h7FFFFFFF;
        if (s < lo) return 32'h80000000;
`else
        if (s > hi || s < lo) return s[31:0];
`endif
        return s[31:0];
    endfunction

    task automatic fill_random8();
        for (int n = 0; n < 64; n++) begin
            a8[n] = 32'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
            b8[n] = 32'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
            c8[n] = 32'hDEADBEEF;
            w8[n] = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                longint s = 0;
                for (int k = 0; k < 8; k++) begin
                    s += longint'($signed(a8[r*8+k])) * longint'($signed(b8[k*8+c]));
                end
                exp8[r*8+c] = narrow(s);
            end
        end
    endtask

    task automatic set2(input logic [31:0] a0, a1, a3_, a4, b0, b1, b3_, b4);
        a2[0] = a0; a2[1] = a1; a2[2] = a3_; a2[3] = a4;
        b2[0] = b0; b2[1] = b1; b2[2] = b3_; b2[3] = b4;
        for (int n = 0; n < 4; n++) c2[n] = 32'hDEADBEEF;
    endtask

    task automatic test_reset();
        if2.start = 1'b0;
        if8.start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        checks++;
        if ({if2.busy, if2.done, if2.c_wr_en} !== 3'b000) begin
            errors++; $display("FAIL reset_flags2: got %b expected 000", {if2.busy, if2.done, if2.c_wr_en});
        end
        checks++;
        if ({if2.a_rd_addr, if2.b_rd_addr, if2.c_wr_addr} !== 6'd0 || if2.c_din !== 32'd0) begin
            errors++; $display("FAIL reset_bus2: addr %h din %h expected 0", {if2.a_rd_addr, if2.b_rd_addr, if2.c_wr_addr}, if2.c_din);
        end
        checks++;
        if ({if8.busy, if8.done, if8.c_wr_en} !== 3'b000 || if8.c_din !== 32'd0 ||
            {if8.a_rd_addr, if8.b_rd_addr, if8.c_wr_addr} !== 18'd0) begin
            errors++; $display("FAIL reset_bus8: flags %b din %h addr %h expected 0", {if8.busy, if8.done, if8.c_wr_en}, if8.c_din, {if8.a_rd_addr, if8.b_rd_addr, if8.c_wr_addr});
        end
        @(posedge clock); #1 rst2 = 1'b0; rst8 = 1'b0;
    endtask

    task automatic test_identity();
        logic [31:0] exp_c [0:3];
        int          exp_t [0:3];
        exp_c = '{32'd1, 32'd2, 32'd3, 32'd4};
        exp_t = '{3, 6, 9, 12};
        set2(1, 0, 0, 1, 1, 2, 3, 4);
        go2();
        wait2(40);
        checks++;
        if (done_cyc2 !== 13) begin
            errors++; $display("FAIL ident_done_cycle: got %0d expected 13", done_cyc2);
        end
        checks++;
        if (if2.busy !== 1'b1) begin
            errors++; $display("FAIL ident_busy_in_done: got %b expected 1", if2.busy);
        end
        checks++;
        if (nwr2 !== 4 || consec2 !== 0) begin
            errors++; $display("FAIL ident_writes: got %0d writes %0d back-to-back expected 4 and 0", nwr2, consec2);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c2[n] !== exp_c[n] || wr_cyc2[n] !== exp_t[n]) begin
                errors++; $display("FAIL ident_c%0d: got %h at cycle %0d expected %h at cycle %0d", n, c2[n], wr_cyc2[n], exp_c[n], exp_t[n]);
            end
        end
        @(negedge clock); #1;
        checks++;
        if (if2.busy !== 1'b0 || if2.done !== 1'b0) begin
            errors++; $display("FAIL ident_idle_after: busy %b done %b expected 0 0", if2.busy, if2.done);
        end
    endtask

    task automatic test_signed();
        logic [31:0] exp_c [0:3];
        exp_c = '{32'd9, 32'd10, 32'hFFFFFFF3, 32'hFFFFFFF2};
        set2(32'hFFFFFFFF, 2, 3, 32'hFFFFFFFC, 5, 6, 7, 8);
        go2();
        wait2(40);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c2[n] !== exp_c[n]) begin
                errors++; $display("FAIL signed_c%0d: got %h expected %h", n, c2[n], exp_c[n]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_v;
`ifdef MATMUL_SATURATE_EN
        exp_v = 32'h7FFFFFFF;
`else
        exp_v = 32'h00000002;
`endif
        set2(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
             32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        go2();
        wait2(40);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c2[n] !== exp_v) begin
                errors++; $display("FAIL overflow_c%0d: got %h expected %h", n, c2[n], exp_v);
            end
        end
    endtask

    task automatic test_start_while_busy();
        set2(1, 0, 0, 1, 4, 3, 2, 1);
        go2();
        repeat (4) @(posedge clock);
        #1 if2.start = 1'b1;
        @(posedge clock); #1 if2.start = 1'b0;
        repeat (7) @(posedge clock);
        #1 if2.start = 1'b1;
        @(posedge clock); #1 if2.start = 1'b0;
        repeat (20) @(negedge clock);
        #1;
        checks++;
        if (ndone2 !== 1 || done_cyc2 !== 13 || nwr2 !== 4) begin
            errors++; $display("FAIL busy_ignore: got %0d done at %0d, %0d writes expected 1 at 13, 4", ndone2, done_cyc2, nwr2);
        end
        checks++;
        if (if2.busy !== 1'b0) begin
            errors++; $display("FAIL busy_ignore_idle: got busy %b expected 0", if2.busy);
        end
        set2(1, 2, 3, 4, 1, 0, 0, 1);
        go2();
        wait2(40);
        checks++;
        if (done_cyc2 !== 13 || c2[0] !== 32'd1 || c2[1] !== 32'd2 || c2[2] !== 32'd3 || c2[3] !== 32'd4) begin
            errors++; $display("FAIL busy_second_run: done %0d c %h %h %h %h expected 13 1 2 3 4", done_cyc2, c2[0], c2[1], c2[2], c2[3]);
        end
    endtask

    // Element e lands at cycle 9e+9, so a reset sampled at edge 100 leaves C[0..10] written.
    task automatic test_reset_midrun();
        int bad = 0;
        fill_random8();
        go8();
        repeat (99) @(posedge clock);
        #1 rst8 = 1'b1;
        @(posedge clock); #1 rst8 = 1'b0;
        @(negedge clock); #1;
        checks++;
        if (if8.busy !== 1'b0 || if8.c_wr_en !== 1'b0) begin
            errors++; $display("FAIL midrun_idle: busy %b wr_en %b expected 0 0", if8.busy, if8.c_wr_en);
        end
        repeat (30) @(negedge clock);
        #1;
        checks++;
        if (nwr8 !== 11 || ndone8 !== 0 || w8[10] !== 1'b1 || w8[11] !== 1'b0) begin
            errors++; $display("FAIL midrun_writes: got %0d writes %0d done w10 %b w11 %b expected 11 0 1 0", nwr8, ndone8, w8[10], w8[11]);
        end
        for (int n = 0; n < 11; n++) if (c8[n] !== exp8[n]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL midrun_partial: got %0d wrong elements expected 0", bad);
        end
        fill_random8();
        go8();
        wait8(700);
        checks++;
        if (done_cyc8 !== 577 || last_wr8 !== 576 || nwr8 !== 64 || consec8 !== 0) begin
            errors++; $display("FAIL midrun_restart: done %0d last %0d writes %0d b2b %0d expected 577 576 64 0", done_cyc8, last_wr8, nwr8, consec8);
        end
        for (int n = 0; n < 64; n++) begin
            checks++;
            if (c8[n] !== exp8[n]) begin
                errors++; $display("FAIL restart_c%0d: got %h expected %h", n, c8[n], exp8[n]);
            end
        end
    endtask

    task automatic test_random8();
        fill_random8();
        go8();
        wait8(700);
        checks++;
        if (done_cyc8 !== 577 || nwr8 !== 64) begin
            errors++; $display("FAIL random_timing: done %0d writes %0d expected 577 64", done_cyc8, nwr8);
        end
        for (int n = 0; n < 64; n++) begin
            checks++;
            if (c8[n] !== exp8[n]) begin
                errors++; $display("FAIL random_c%0d: got %h expected %h", n, c8[n], exp8[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_overflow();
        test_start_while_busy();
        test_reset_midrun();
        test_random8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
